// File: rtl/error_serializer.sv
// Serializes a snapshot of NUM_CHAINS error counters as framed bits: header, payload, even parity.
// The snapshot is taken on a synchronized SAVE_DATA rising edge and deferred while a frame is in flight.
module error_serializer #(
   parameter int unsigned           NUM_CHAINS  = 4,
   parameter int unsigned           CNT_WIDTH   = 16,
   parameter int unsigned           HDR_WIDTH   = 8,
   parameter logic [HDR_WIDTH-1:0]  HEADER      = HDR_WIDTH'(8'hA5),
   parameter bit                    MSB_FIRST   = 1'b0,
   parameter bit                    AUTO_REPEAT = 1'b0
) (
   input  logic                            DATA_CLK,
   input  logic                            RST,
   input  logic                            SAVE_DATA,
   input  logic                            START,
   input  logic [NUM_CHAINS*CNT_WIDTH-1:0] ERR_IN,
   output logic                            DATA_OUT,
   output logic                            FRAME_VALID,
   output logic                            BUSY,
   output logic                            DONE,
   output logic                            SNAP_OVR
);

   localparam int unsigned TOT = NUM_CHAINS * CNT_WIDTH;
   localparam int unsigned HCW = (HDR_WIDTH > 1) ? $clog2(HDR_WIDTH) : 1;
   localparam int unsigned DCW = (TOT > 1) ? $clog2(TOT) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_PAR  = 2'd3;

   logic [2:0]           sync_q;
   logic                 snap_req;
   logic [TOT-1:0]       snap_q, snap_d;
   logic                 pending_q, pending_d;
   logic                 ovr_q, ovr_d;
   logic [1:0]           state_q, state_d;
   logic [HCW-1:0]       hdr_cnt_q, hdr_cnt_d;
   logic [DCW-1:0]       dat_cnt_q, dat_cnt_d;
   logic [HDR_WIDTH-1:0] hdr_sh_q, hdr_sh_d;
   logic [TOT-1:0]       pay_q, pay_d, pay_load;
   logic                 par_q, par_d;
   logic                 dout_q, dout_d;
   logic                 fv_q, fv_d;
   logic                 done_q, done_d;
   logic                 idle;
   logic                 load, shift_out;

   assign snap_req = sync_q[1] & ~sync_q[2];
   assign idle     = (state_q == S_IDLE);

   always_comb begin
      snap_d    = snap_q;
      pending_d = pending_q;
      ovr_d     = ovr_q;
      if (snap_req && !idle) begin
         if (pending_q) ovr_d = 1'b1;
         else           pending_d = 1'b1;
      end
      if (idle && (snap_req || pending_q)) begin
         snap_d    = ERR_IN;
         pending_d = 1'b0;
      end
   end

   // Payload is reordered at load time so the shifter always emits bit 0 next.
   for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_chain
      for (genvar b = 0; b < CNT_WIDTH; b++) begin : g_bit
         assign pay_load[c*CNT_WIDTH + b] = MSB_FIRST ? snap_d[c*CNT_WIDTH + CNT_WIDTH-1-b]
                                                      : snap_d[c*CNT_WIDTH + b];
      end
   end

   always_comb begin
      state_d   = state_q;
      hdr_cnt_d = hdr_cnt_q;
      dat_cnt_d = dat_cnt_q;
      hdr_sh_d  = hdr_sh_q;
      pay_d     = pay_q;
      par_d     = par_q;
      dout_d    = 1'b0;
      fv_d      = 1'b0;
      done_d    = 1'b0;
      load      = 1'b0;
      shift_out = 1'b0;
      case (state_q)
         S_IDLE: if (START) load = 1'b1;
         S_HDR: begin
            if (hdr_cnt_q == HCW'(HDR_WIDTH-1)) begin
               state_d   = S_DATA;
               dat_cnt_d = '0;
               shift_out = 1'b1;
            end else begin
               hdr_cnt_d = hdr_cnt_q + 1'b1;
               dout_d    = hdr_sh_q[HDR_WIDTH-1];
               hdr_sh_d  = hdr_sh_q << 1;
               fv_d      = 1'b1;
            end
         end
         S_DATA: begin
            if (dat_cnt_q == DCW'(TOT-1)) begin
               state_d = S_PAR;
               dout_d  = par_q;
               fv_d    = 1'b1;
            end else begin
               dat_cnt_d = dat_cnt_q + 1'b1;
               shift_out = 1'b1;
            end
         end
         default: begin
            done_d = 1'b1;
            if (AUTO_REPEAT && !pending_q && !snap_req) load = 1'b1;
            else                                         state_d = S_IDLE;
         end
      endcase
      if (shift_out) begin
         dout_d = pay_q[0];
         fv_d   = 1'b1;
         pay_d  = pay_q >> 1;
         par_d  = par_q ^ pay_q[0];
      end
      if (load) begin
         state_d   = S_HDR;
         hdr_cnt_d = '0;
         hdr_sh_d  = HEADER << 1;
         dout_d    = HEADER[HDR_WIDTH-1];
         fv_d      = 1'b1;
         pay_d     = pay_load;
         par_d     = 1'b0;
      end
   end

   always_ff @(posedge DATA_CLK) begin
      if (RST) begin
         sync_q    <= '0;
         snap_q    <= '0;
         pending_q <= 1'b0;
         ovr_q     <= 1'b0;
         state_q   <= S_IDLE;
         hdr_cnt_q <= '0;
         dat_cnt_q <= '0;
         hdr_sh_q  <= '0;
         pay_q     <= '0;
         par_q     <= 1'b0;
         dout_q    <= 1'b0;
         fv_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         sync_q    <= {sync_q[1:0], SAVE_DATA};
         snap_q    <= snap_d;
         pending_q <= pending_d;
         ovr_q     <= ovr_d;
         state_q   <= state_d;
         hdr_cnt_q <= hdr_cnt_d;
         dat_cnt_q <= dat_cnt_d;
         hdr_sh_q  <= hdr_sh_d;
         pay_q     <= pay_d;
         par_q     <= par_d;
         dout_q    <= dout_d;
         fv_q      <= fv_d;
         done_q    <= done_d;
      end
   end

   assign DATA_OUT    = dout_q;
   assign FRAME_VALID = fv_q;
   assign BUSY        = (state_q != S_IDLE);
   assign DONE        = done_q;
   assign SNAP_OVR    = ovr_q;

endmodule

// File: tb/tb_error_serializer.sv
// Directed bench for error_serializer: four instances cover defaults, MSB_FIRST, AUTO_REPEAT
// and a minimal 6-bit frame configuration.
module tb_error_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  save = '0;
   logic [3:0]  start = '0;
   logic [63:0] err0 = '0, err1 = '0, err2 = '0;
   logic [3:0]  err3 = '0;
   wire  [3:0]  dout, fv, busy, done, ovr;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   logic [127:0] got;
   int           gaps;
   logic [63:0]  base;

   always #5 clk = ~clk;

   error_serializer u0 (
      .DATA_CLK(clk), .RST(rst), .SAVE_DATA(save[0]), .START(start[0]), .ERR_IN(err0),
      .DATA_OUT(dout[0]), .FRAME_VALID(fv[0]), .BUSY(busy[0]), .DONE(done[0]), .SNAP_OVR(ovr[0]));

   error_serializer #(.MSB_FIRST(1'b1)) u1 (
      .DATA_CLK(clk), .RST(rst), .SAVE_DATA(save[1]), .START(start[1]), .ERR_IN(err1),
      .DATA_OUT(dout[1]), .FRAME_VALID(fv[1]), .BUSY(busy[1]), .DONE(done[1]), .SNAP_OVR(ovr[1]));

   error_serializer #(.AUTO_REPEAT(1'b1)) u2 (
      .DATA_CLK(clk), .RST(rst), .SAVE_DATA(save[2]), .START(start[2]), .ERR_IN(err2),
      .DATA_OUT(dout[2]), .FRAME_VALID(fv[2]), .BUSY(busy[2]), .DONE(done[2]), .SNAP_OVR(ovr[2]));

   error_serializer #(.NUM_CHAINS(1), .CNT_WIDTH(4), .HDR_WIDTH(1), .HEADER(1'b1)) u3 (
      .DATA_CLK(clk), .RST(rst), .SAVE_DATA(save[3]), .START(start[3]), .ERR_IN(err3),
      .DATA_OUT(dout[3]), .FRAME_VALID(fv[3]), .BUSY(busy[3]), .DONE(done[3]), .SNAP_OVR(ovr[3]));

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse START for one cycle; the first frame bit must be visible at the very next sample.
   task automatic start_frame(input int k, input string tag);
      int w;
      w = 0;
      start[k] = 1'b1;
      tick();
      start[k] = 1'b0;
      while (fv[k] !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      got  = '0;
      gaps = 0;
      chk({tag, " latency"}, 128'(w), 128'd0);
   endtask

   task automatic collect(input int k, input int off, input int n);
      for (int i = 0; i < n; i++) begin
         got[off+i] = dout[k];
         if (fv[k] !== 1'b1) gaps++;
         tick();
      end
   endtask

   function automatic logic [127:0] mkframe(input logic [15:0] hdr, input int hw, input logic [63:0] d,
                                            input int nch, input int cw, input bit msb);
      logic [127:0] f;
      int           p;
      logic         v, par;
      f   = '0;
      p   = 0;
      par = 1'b0;
      for (int i = 0; i < hw; i++) begin
         f[p] = hdr[hw-1-i];
         p++;
      end
      for (int c = 0; c < nch; c++) begin
         for (int b = 0; b < cw; b++) begin
            v    = msb ? d[c*cw + cw-1-b] : d[c*cw + b];
            f[p] = v;
            par  = par ^ v;
            p++;
         end
      end
      f[p] = par;
      return f;
   endfunction

   initial begin
      repeat (3) tick();
      for (int k = 0; k < 4; k++)
         chk($sformatf("reset u%0d", k), 128'({dout[k], fv[k], busy[k], done[k], ovr[k]}), 128'd0);
      rst = 1'b0;
      repeat (6) tick();
      chk("auto no spontaneous frame", 128'({busy[2], fv[2]}), 128'd0);

      // basic frame
      base = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
      err0 = base;
      save[0] = 1'b1;
      repeat (4) tick();
      start_frame(0, "basic");
      collect(0, 0, 73);
      chk("basic done", 128'(done[0]), 128'd1);
      chk("basic fv after", 128'(fv[0]), 128'd0);
      chk("basic gaps", 128'(gaps), 128'd0);
      chk("basic header", 128'({got[0], got[1], got[2], got[3], got[4], got[5], got[6], got[7]}), 128'hA5);
      chk("basic chain0 lsb", 128'(got[8]), 128'd1);
      chk("basic chain1 bit1", 128'({got[25], got[24]}), 128'b10);
      chk("basic parity", 128'(got[72]), 128'd1);
      chk("basic frame", got, mkframe(16'hA5, 8, base, 4, 16, 1'b0));
      tick();
      chk("basic done one cycle", 128'(done[0]), 128'd0);
      save[0] = 1'b0;
      repeat (3) tick();

      // MSB-first bit order
      err1 = 64'h0000_0000_0000_8000;
      save[1] = 1'b1;
      repeat (4) tick();
      start_frame(1, "msb");
      collect(1, 0, 73);
      chk("msb first payload bit", 128'(got[8]), 128'd1);
      chk("msb rest zero", 128'(got[71:9]), 128'd0);
      chk("msb parity", 128'(got[72]), 128'd1);
      chk("msb frame", got, mkframe(16'hA5, 8, err1, 4, 16, 1'b1));

      // deferred snapshot and overrun
      start_frame(0, "defer");
      collect(0, 0, 20);
      err0 = '1;
      save[0] = 1'b1;
      collect(0, 20, 10);
      save[0] = 1'b0;
      collect(0, 30, 10);
      save[0] = 1'b1;
      collect(0, 40, 33);
      chk("defer frame unchanged", got, mkframe(16'hA5, 8, base, 4, 16, 1'b0));
      chk("defer gaps", 128'(gaps), 128'd0);
      chk("defer ovr", 128'(ovr[0]), 128'd1);
      save[0] = 1'b0;
      repeat (3) tick();
      start_frame(0, "defer next");
      collect(0, 0, 73);
      chk("defer next ones", 128'(got[71:8]), 128'({64{1'b1}}));
      chk("defer next parity", 128'(got[72]), 128'd0);
      chk("defer next frame", got, mkframe(16'hA5, 8, 64'hFFFF_FFFF_FFFF_FFFF, 4, 16, 1'b0));
      repeat (3) tick();

      // reset at payload bit 20
      start_frame(0, "rst");
      collect(0, 0, 28);
      rst = 1'b1;
      tick();
      chk("rst mid-frame outputs", 128'({dout[0], fv[0], busy[0]}), 128'd0);
      chk("rst ovr cleared", 128'(ovr[0]), 128'd0);
      rst = 1'b0;
      tick();
      start_frame(0, "post-rst");
      collect(0, 0, 73);
      chk("post-rst zero frame", got, mkframe(16'hA5, 8, 64'd0, 4, 16, 1'b0));

      // auto repeat
      err2 = 64'h1234_5678_9ABC_DEF0;
      save[2] = 1'b1;
      repeat (4) tick();
      start_frame(2, "auto");
      collect(2, 0, 73);
      chk("auto done f1", 128'(done[2]), 128'd1);
      chk("auto no idle gap", 128'(fv[2]), 128'd1);
      chk("auto parity", 128'(got[72]), 128'd0);
      chk("auto frame1", got, mkframe(16'hA5, 8, err2, 4, 16, 1'b0));
      got  = '0;
      collect(2, 0, 73);
      chk("auto done f2", 128'(done[2]), 128'd1);
      chk("auto gaps", 128'(gaps), 128'd0);
      chk("auto frame2", got, mkframe(16'hA5, 8, err2, 4, 16, 1'b0));

      // minimal configuration
      err3 = 4'b1011;
      save[3] = 1'b1;
      repeat (4) tick();
      start_frame(3, "sweep");
      collect(3, 0, 6);
      chk("sweep bits", 128'(got[5:0]), 128'b110111);
      chk("sweep done", 128'(done[3]), 128'd1);
      chk("sweep fv after", 128'(fv[3]), 128'd0);
      save[3] = 1'b0;
      repeat (3) tick();

      // snapshot request coinciding with START
      err3 = 4'b0110;
      save[3] = 1'b1;
      tick();
      tick();
      start_frame(3, "coincide");
      collect(3, 0, 6);
      chk("coincide bits", 128'(got[5:0]), 128'b001101);

      rst = 1'b1;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/error_serializer.md
ERROR_SERIALIZER -- requirements
Module: error_serializer

Interface
REQ-001 SHALL have parameter NUM_CHAINS, default 4, number of error counters serialized per frame (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of each error counter (1..32).
REQ-003 SHALL have parameter HDR_WIDTH, default 8, number of frame header bits (1..16).
REQ-004 SHALL have parameter HEADER, default 8'hA5, header pattern, sent MSB first.
REQ-005 SHALL have parameter MSB_FIRST, default 0, payload bit order: 0 = LSB first, 1 = MSB first.
REQ-006 SHALL have parameter AUTO_REPEAT, default 0, 1 = start next frame immediately without START.
REQ-007 SHALL have port DATA_CLK, input, 1, clock; all logic on its rising edge.
REQ-008 SHALL have port RST, input, 1, reset: synchronous, active-high.
REQ-009 SHALL have port SAVE_DATA, input, 1, asynchronous snapshot request; a rising edge captures the counters.
REQ-010 SHALL have port START, input, 1, frame start request, sampled in IDLE only.
REQ-011 SHALL have port ERR_IN, input, NUM_CHAINS*CNT_WIDTH, flattened counters; chain i at bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-012 SHALL have port DATA_OUT, output, 1, registered serial data.
REQ-013 SHALL have port FRAME_VALID, output, 1, high on every cycle DATA_OUT carries a frame bit.
REQ-014 SHALL have port BUSY, output, 1, high whenever state is not IDLE.
REQ-015 SHALL have port DONE, output, 1, one-cycle pulse at frame end.
REQ-016 SHALL have port SNAP_OVR, output, 1, sticky flag: a second snapshot request arrived while one was pending.

Function
REQ-017 SHALL pass SAVE_DATA through a 2-flop synchronizer, then a rising-edge detector; the edge pulse is snap_req.
REQ-018 SHALL, on snap_req in IDLE, load the snapshot register from ERR_IN on the same edge.
REQ-019 SHALL, on snap_req while BUSY, set a pending flag and load the snapshot on the first IDLE cycle; the frame in flight is never altered.
REQ-020 SHALL set SNAP_OVR when snap_req arrives with the pending flag already set; the second request SHALL be dropped; SNAP_OVR clears only on RST.
REQ-021 SHALL implement FSM IDLE -> HDR -> DATA -> PAR -> IDLE.
- IDLE -> HDR: when START=1.
- HDR: lasts HDR_WIDTH cycles.
- DATA: lasts NUM_CHAINS*CNT_WIDTH cycles.
- PAR: lasts 1 cycle.
- PAR -> HDR: when AUTO_REPEAT=1 and no snapshot is pending.
- PAR -> IDLE: otherwise.
REQ-022 SHALL have one-cycle latency: START high at edge k puts HEADER[HDR_WIDTH-1] on DATA_OUT, with FRAME_VALID=1, from edge k+1.
REQ-023 SHALL latch the payload source from the snapshot register on the IDLE->HDR and PAR->HDR transitions.
REQ-024 SHALL send payload chain 0 first, through chain NUM_CHAINS-1; bit order within each chain is per MSB_FIRST.
REQ-025 SHALL send in PAR one even-parity bit equal to the XOR of all payload bits.
REQ-026 SHALL size bit counters as $clog2 of the segment length, with no wrap glitch between segments.
REQ-027 SHALL give a total frame length of HDR_WIDTH + NUM_CHAINS*CNT_WIDTH + 1 bits, contiguous, with FRAME_VALID never dropping mid-frame.
REQ-028 SHALL pulse DONE for one cycle on the cycle after the PAR bit, including in AUTO_REPEAT.
REQ-029 SHALL drive DATA_OUT=0 whenever FRAME_VALID=0.
REQ-030 SHALL ignore START while BUSY; START held high in IDLE begins exactly one frame per IDLE visit.
REQ-031 SHALL, when snap_req and START coincide in IDLE, load the snapshot first so the frame carries the new values.

Reset
REQ-032 SHALL, on RST=1 at any edge (including mid-frame), force state IDLE and DATA_OUT=0, FRAME_VALID=0, BUSY=0, DONE=0, SNAP_OVR=0.
REQ-033 SHALL, on reset, clear the snapshot register, pending flag, synchronizer flops and bit counters to 0.
REQ-034 SHALL, after RST deasserts, wait in IDLE for START; no frame emits spontaneously, even with AUTO_REPEAT=1.

Verification (defaults unless stated)
REQ-035 SHALL check basic frame: ERR_IN={16'h0004,16'h0003,16'h0002,16'h0001}, SAVE_DATA rise, START pulse.
- Expect 73 valid bits: A5 MSB first, then 0x0001 LSB first ... 0x0004, then parity bit 1 (five ones).
- DONE pulses one cycle later.
REQ-036 SHALL check bit order: MSB_FIRST=1, chain0=16'h8000, others 0 -> first payload bit 1, the remaining 63 payload bits 0, parity 1.
REQ-037 SHALL check deferred snapshot: SAVE_DATA rises mid-frame with ERR_IN changed to all 16'hFFFF.
- The current frame is unchanged.
- The next frame carries 64 ones with parity 0.
- Two rises mid-frame -> SNAP_OVR=1.
REQ-038 SHALL check reset mid-frame: RST at payload bit 20 -> next cycle DATA_OUT=0, FRAME_VALID=0, BUSY=0; a following START emits a frame of all-zero payload.
REQ-039 SHALL check AUTO_REPEAT=1: one START -> back-to-back 73-bit frames with no idle gap and a DONE pulse each frame.
REQ-040 SHALL check parameter sweep: NUM_CHAINS=1, CNT_WIDTH=4, HDR_WIDTH=1 -> 6-bit frames, correct parity.
